// File: rtl/switch_pkg.sv
// rtl/switch_pkg.sv - shared widths, depths and payload type for the switch datapath
//
// Purpose: common constants for the 8x8 switch output-port FIFOs.
//   PAYLOAD_W       payload width in bits
//   PORT_FIFO_DEPTH entries per output-port FIFO
//   DROP_CNT_W      width of the rejected-push counter
//   payload_t       one payload word
package switch_pkg;

  localparam int PAYLOAD_W       = 32;
  localparam int PORT_FIFO_DEPTH = 128;
  localparam int DROP_CNT_W      = 16;

  typedef logic [PAYLOAD_W-1:0] payload_t;

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - storage array with synchronous write and asynchronous read
//
// Purpose: payload storage for switch_fifo; no reset, contents undefined until written.
// Ports:
//   clk      in   write clock (rising edge)
//   wr_en    in   write enable
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_addr  in   read address
//   rd_data  out  word at rd_addr, combinational
module fifo_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 128,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/switch_fifo.sv
// rtl/switch_fifo.sv - show-ahead payload FIFO with occupancy, almost-full and sticky error flags
//
// Purpose: per-output-port queue between arbiter (push) and output stage (pop).
//   Simultaneous push/pop is supported, including push into a full FIFO when a
//   pop is accepted in the same cycle. The head word is shown on data_out
//   whenever the FIFO is not empty.
// Optional feature: SWITCH_FIFO_DROP_CNT_EN adds the saturating drop_cnt port.
// Ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-low reset
//   push         in   write request
//   data_in      in   write payload
//   pop          in   read request
//   clr_err      in   synchronous clear of overflow/underflow (and drop_cnt)
//   data_out     out  head word, valid while empty=0
//   full         out  level == DEPTH
//   empty        out  level == 0
//   almost_full  out  level >= AFULL_TH
//   level        out  occupancy 0..DEPTH
//   overflow     out  sticky, push rejected
//   underflow    out  sticky, pop while empty
//   drop_cnt     out  saturating rejected-push count (SWITCH_FIFO_DROP_CNT_EN only)
module switch_fifo
  import switch_pkg::*;
#(
  parameter int WIDTH    = PAYLOAD_W,
  parameter int DEPTH    = PORT_FIFO_DEPTH,
  parameter int AFULL_TH = DEPTH - 8,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  input  logic             clr_err,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic [AW:0]      level,
  output logic             overflow,
  output logic             underflow
`ifdef SWITCH_FIFO_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

  localparam logic [AW:0] FULL_LVL  = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_LVL = (AW+1)'(AFULL_TH);

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic          push_ok;
  logic          pop_ok;
  logic          ovf_event;
  logic          udf_event;

  // Flags derive from the registered level only, so no input reaches an output
  // combinationally.
  assign empty       = (level == '0);
  assign full        = (level == FULL_LVL);
  assign almost_full = (level >= AFULL_LVL);

  // A pop frees a slot in the same cycle, which is what lets a push into a
  // full FIFO succeed when it is paired with a pop.
  assign pop_ok    = pop && !empty;
  assign push_ok   = push && (!full || pop_ok);
  assign ovf_event = push && !push_ok;
  assign udf_event = pop && empty;

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (push_ok),
    .wr_addr (head),
    .wr_data (data_in),
    .rd_addr (tail),
    .rd_data (data_out)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      level <= '0;
    end else begin
      if (push_ok) begin
        head <= head + 1'b1;
      end
      if (pop_ok) begin
        tail <= tail + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // A new error in the same cycle as clr_err leaves its flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_event || (overflow && !clr_err);
      underflow <= udf_event || (underflow && !clr_err);
    end
  end

`ifdef SWITCH_FIFO_DROP_CNT_EN
  // The clear and a same-cycle rejection combine to a count of one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt <= '0;
    end else if (clr_err) begin
      drop_cnt <= ovf_event ? DROP_CNT_W'(1) : '0;
    end else if (ovf_event && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_switch_fifo.sv
// tb/tb_switch_fifo.sv - self-checking bench for switch_fifo against a queue model
module tb_switch_fifo;

  localparam int WIDTH    = 32;
  localparam int DEPTH    = 128;
  localparam int AFULL_TH = DEPTH - 8;
  localparam int AW       = $clog2(DEPTH);

  logic             clk;
  logic             reset;
  logic             push;
  logic [WIDTH-1:0] data_in;
  logic             pop;
  logic             clr_err;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic [AW:0]      level;
  logic             overflow;
  logic             underflow;
`ifdef SWITCH_FIFO_DROP_CNT_EN
  logic [15:0]      drop_cnt;
`endif

  switch_fifo #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .AFULL_TH (AFULL_TH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .data_in     (data_in),
    .pop         (pop),
    .clr_err     (clr_err),
    .data_out    (data_out),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .level       (level),
    .overflow    (overflow),
    .underflow   (underflow)
`ifdef SWITCH_FIFO_DROP_CNT_EN
    ,
    .drop_cnt    (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: a plain queue plus sticky flags.
  logic [WIDTH-1:0] q[$];
  logic             m_ovf = 1'b0;
  logic             m_udf = 1'b0;
  int               m_drop = 0;
  int               popped = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic p, input logic [WIDTH-1:0] d, input logic o, input logic c);
    int  sz;
    bit  pop_ok, push_ok, ovf_ev, udf_ev;
    sz      = q.size();
    pop_ok  = o && (sz != 0);
    push_ok = p && ((sz < DEPTH) || pop_ok);
    ovf_ev  = p && !push_ok;
    udf_ev  = o && (sz == 0);
    if (pop_ok) begin
      void'(q.pop_front());
      popped++;
    end
    if (push_ok) q.push_back(d);
    m_ovf = ovf_ev || (m_ovf && !c);
    m_udf = udf_ev || (m_udf && !c);
    if (c) m_drop = ovf_ev ? 1 : 0;
    else if (ovf_ev && m_drop < 65535) m_drop++;
  endtask

  task automatic check_all(input string tag);
    int sz;
    sz = q.size();
    chk({tag, ".level"}, 64'(level), 64'(sz));
    chk({tag, ".empty"}, 64'(empty), 64'(sz == 0));
    chk({tag, ".full"}, 64'(full), 64'(sz == DEPTH));
    chk({tag, ".afull"}, 64'(almost_full), 64'(sz >= AFULL_TH));
    chk({tag, ".ovf"}, 64'(overflow), 64'(m_ovf));
    chk({tag, ".udf"}, 64'(underflow), 64'(m_udf));
    if (sz != 0) chk({tag, ".data"}, 64'(data_out), 64'(q[0]));
`ifdef SWITCH_FIFO_DROP_CNT_EN
    chk({tag, ".drop"}, 64'(drop_cnt), 64'(m_drop));
`endif
  endtask

  // Inputs change at the falling edge; outputs are checked at the next falling edge.
  task automatic step(input logic p, input logic [WIDTH-1:0] d, input logic o, input logic c,
                      input string tag);
    push = p; data_in = d; pop = o; clr_err = c;
    @(posedge clk);
    model_update(p, d, o, c);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    logic [WIDTH-1:0] w;
    int               budget;

    reset = 1'b0; push = 1'b0; data_in = '0; pop = 1'b0; clr_err = 1'b0;
    repeat (2) @(negedge clk);
    check_all("reset");
    reset = 1'b1;
    step(0, 0, 0, 0, "idle");

    // Fill to full, watching almost_full and full boundaries.
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 32'hA000_0000 + 32'(i), 0, 0, "fill");
      if (i == AFULL_TH - 2) chk("afull_before_th", 64'(almost_full), 64'(0));
      if (i == AFULL_TH - 1) chk("afull_at_th", 64'(almost_full), 64'(1));
    end
    chk("full_after_128", 64'(full), 64'(1));
    step(1, 32'hDEAD_DEAD, 0, 0, "push129");
    chk("ovf_129", 64'(overflow), 64'(1));
    chk("level_129", 64'(level), 64'(DEPTH));
`ifdef SWITCH_FIFO_DROP_CNT_EN
    chk("drop_129", 64'(drop_cnt), 64'(1));
`endif
    step(0, 0, 0, 1, "clr_ovf");

    // Push and pop together while full.
    step(1, 32'h0000_BEEF, 1, 0, "full_pushpop");
    chk("full_pp_data", 64'(data_out), 64'(32'hA000_0001));
    chk("full_pp_full", 64'(full), 64'(1));
    while (q.size() > 1) step(0, 0, 1, 0, "drain");
    chk("beef_last", 64'(data_out), 64'(32'h0000_BEEF));
    step(0, 0, 1, 0, "drain_last");

    // Push and pop together while empty.
    step(1, 32'h0000_1234, 1, 0, "empty_pushpop");
    chk("empty_pp_udf", 64'(underflow), 64'(1));
    chk("empty_pp_level", 64'(level), 64'(1));
    chk("empty_pp_data", 64'(data_out), 64'(32'h0000_1234));
    step(0, 0, 0, 1, "clr_udf");
    chk("udf_cleared", 64'(underflow), 64'(0));
    step(0, 0, 1, 0, "pop_1234");

    // Random traffic across pointer wrap, alternating fill-biased and drain-biased phases.
    popped = 0;
    budget = 0;
    while (popped < 3 * DEPTH && budget < 8000) begin
      bit fill_phase;
      bit p, o, c;
      fill_phase = ((budget / 150) % 2) == 0;
      p = fill_phase ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
      o = fill_phase ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8);
      c = ($urandom_range(0, 31) == 0);
      w = $urandom;
      step(p, w, o, c, "rand");
      budget++;
    end
    chk("rand_budget", 64'(popped >= 3 * DEPTH), 64'(1));

    // Bring level to 57, then reset between clock edges.
    while (q.size() > 0) step(0, 0, 1, 0, "pre_rst_drain");
    for (int i = 0; i < 57; i++) step(1, 32'hC000_0000 + 32'(i), 0, 0, "pre_rst_fill");
    step(0, 0, 0, 1, "pre_rst_clr");
    chk("level_57", 64'(level), 64'(57));
    #2 reset = 1'b0;
    #1;
    q.delete(); m_ovf = 1'b0; m_udf = 1'b0; m_drop = 0;
    check_all("async_rst");
    @(negedge clk);
    reset = 1'b1;
    step(1, 32'h5A5A_0001, 0, 0, "post_rst_push");
    chk("post_rst_data", 64'(data_out), 64'(32'h5A5A_0001));
    chk("post_rst_level", 64'(level), 64'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/switch_fifo.md
# switch_fifo

Parametrised payload FIFO for the 8x8 switch datapath, one instance per output port between the arbiter (push side) and the output stage (pop side). It replaces the fixed 32x128 queue and adds simultaneous push/pop, an occupancy output, an almost-full threshold for arbiter back-pressure, and sticky overflow/underflow error flags. Read data is show-ahead: the head word is presented on `data_out` whenever the FIFO is not empty.

## Interface
- `WIDTH`, 32: payload width in bits.
- `DEPTH`, 128: number of entries; power of two, at least 2.
- `AFULL_TH`, DEPTH-8: `almost_full` asserts when `level` >= `AFULL_TH`; range 1..DEPTH.
- `AW` is a localparam equal to $clog2(DEPTH).
- `clk`  in  1  the single clock; rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `push`  in  1  write request from the arbiter.
- `data_in`  in  WIDTH  write payload.
- `pop`  in  1  read request from the output stage.
- `clr_err`  in  1  synchronous clear of `overflow` and `underflow`.
- `data_out`  out  WIDTH  head-of-queue word; valid only while `empty`=0.
- `full`  out  1  `level` == DEPTH.
- `empty`  out  1  `level` == 0.
- `almost_full`  out  1  `level` >= `AFULL_TH`.
- `level`  out  AW+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky; set when a push is rejected.
- `underflow`  out  1  sticky; set when a pop is requested while empty.
- `drop_cnt`  out  16  rejected-push count; present only with `SWITCH_FIFO_DROP_CNT_EN`.

## Operation
- State consists of `head`[AW-1:0], `tail`[AW-1:0], `level`[AW:0], and the memory array. Pointers wrap modulo DEPTH through natural overflow.
- Pop is accepted (`pop_ok`) when `pop` is high and `empty` is low. On accept, `tail` increments.
- Push is accepted (`push_ok`) when `push` is high and either `full` is low or `pop_ok` is high. On accept, `mem[head]` is written with `data_in` and `head` increments.
- `level` updates as follows:
  - increments on `push_ok` alone;
  - decrements on `pop_ok` alone;
  - is unchanged when both are accepted.
- Full with push and pop in the same cycle: both are accepted. The old head word is popped, the new word is written into the freed slot, and `full` stays 1.
- Empty with push and pop in the same cycle: the push is accepted, the pop is ignored, and `underflow` is set.
- `overflow` is set when `push` is high and the push is not accepted. `underflow` is set when `pop` is high and `empty` is high.
- Error-flag priority: `clr_err` clears both flags, but a new error event in the same cycle wins and leaves its flag set.
- Reset values: `head`=`tail`=0, `level`=0, `empty`=1, `full`=0, `almost_full`=0, `overflow`=`underflow`=0, `drop_cnt`=0.
- Memory contents are not reset. `data_out` is undefined while `empty`=1.
- Reset asserted mid-operation discards all queued data immediately, without waiting for a clock edge.

## Timing
- All outputs are functions of registered state only; there is no combinational path from `push`, `pop` or `data_in` to any output.
- Write-to-read latency is 1 cycle. A word pushed at edge N is on `data_out` after edge N, with `empty`=0, when the FIFO was previously empty.
- A pop accepted at edge N presents the next word after edge N.
- Flags and `level` reflect the accepts of edge N immediately after edge N.
- The memory has a synchronous write port and an asynchronous read port.

## Configuration
- `SWITCH_FIFO_DROP_CNT_EN` defined:
  - `drop_cnt`[15:0] port exists;
  - it increments on each rejected push and saturates at 16'hFFFF;
  - `clr_err` clears it to 0.
- `SWITCH_FIFO_DROP_CNT_EN` undefined: the port and its counter logic are absent. All other behaviour is identical.

## Structure
- Package `switch_pkg` holds:
  - `PAYLOAD_W`=32;
  - `PORT_FIFO_DEPTH`=128;
  - `DROP_CNT_W`=16;
  - typedef `payload_t` (logic [PAYLOAD_W-1:0]).
- Sub-module `fifo_ram`: parametrised storage array (WIDTH, DEPTH) with a write-enable/address/data port and an asynchronous read address/data port. Pointer, level and flag logic stay in `switch_fifo`.

## Test plan
- Reset, then idle: `empty`=1, `full`=0, `level`=0, `overflow`=0, `underflow`=0.
- Push 0xA0000000..0xA000007F (128 words; DEPTH=128, AFULL_TH=120):
  - `almost_full` rises after the 120th push;
  - `full`=1 after the 128th push;
  - a 129th push sets `overflow`, leaves `level`=128, and with the macro gives `drop_cnt`=1.
- With the FIFO full, push 0xBEEF and pop in the same cycle: `level` stays 128, `full` stays 1, `data_out` advances to 0xA0000001, and 0xBEEF is read last.
- From empty, push 0x1234 and pop in the same cycle: `underflow`=1, `level`=1, `data_out`=0x1234. Then `clr_err` clears `underflow`.
- Fill and drain 3×DEPTH words with random push/pop: the data order matches a reference queue across pointer wrap, and `level` always matches the model.
- Assert reset mid-stream with `level`=57: all outputs return to their reset values asynchronously, and the first push after release appears on `data_out` with `level`=1.
